// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC, req/ack instruction fetch, IF/ID register
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [5:0]  op_o,
  output logic        valid_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] SQUASH = 2'd3;

  logic [1:0]  state;
  logic [31:0] pcQ;
  logic [31:0] tgtQ;
  logic [31:0] bufInst;
  logic [31:0] bufPc;
  logic [31:0] redirAligned;
  logic [31:0] pcNext;

  assign redirAligned = redirect_pc_i & ~32'h3;
  assign pcNext       = pcQ + 32'd4;
  assign imem_req_o   = (state == REQ) || (state == SQUASH);
  assign imem_addr_o  = pcQ;
  assign op_o         = inst_o[31:26];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pcQ     <= RESET_PC;
      tgtQ    <= 32'h0;
      bufInst <= 32'h0;
      bufPc   <= 32'h0;
      inst_o  <= 32'h0;
      pc_o    <= 32'h0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_i) begin
            pcQ     <= redirAligned;
            valid_o <= 1'b0;
          end
          state <= REQ;
        end
        REQ: begin
          if (flush_i) begin
            valid_o <= 1'b0;
            // An outstanding request cannot be withdrawn; park the target until it completes.
            if (imem_ack_i) begin
              pcQ <= redirAligned;
            end else begin
              tgtQ  <= redirAligned;
              state <= SQUASH;
            end
          end else if (imem_ack_i) begin
            pcQ <= pcNext;
            if (stall_i) begin
              bufInst <= imem_data_i;
              bufPc   <= pcNext;
              state   <= HOLD;
            end else begin
              inst_o  <= imem_data_i;
              pc_o    <= pcNext;
              valid_o <= 1'b1;
            end
          end else if (!stall_i) begin
            valid_o <= 1'b0;
          end
        end
        HOLD: begin
          if (flush_i) begin
            pcQ     <= redirAligned;
            valid_o <= 1'b0;
            state   <= REQ;
          end else if (!stall_i) begin
            inst_o  <= bufInst;
            pc_o    <= bufPc;
            valid_o <= 1'b1;
            state   <= REQ;
          end
        end
        default: begin
          valid_o <= 1'b0;
          if (imem_ack_i) begin
            pcQ   <= flush_i ? redirAligned : tgtQ;
            state <= REQ;
          end else if (flush_i) begin
            tgtQ <= redirAligned;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  typedef struct {
    int          ack;
    int          stall;
    int          flush;
    int          drop;
    logic [31:0] redir;
    int          expReq;
    logic [31:0] expAddr;
    int          expValid;
    logic [31:0] expPc;
    int          expNew;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, ackA, stallA, flushA;
  logic [31:0] dataA, redirA;
  logic        reqA, validA;
  logic [31:0] addrA, instA, pcA;
  logic [5:0]  opA;

  logic        rstB, ackB, stallB, flushB;
  logic [31:0] dataB, redirB;
  logic        reqB, validB;
  logic [31:0] addrB, instB, pcB;
  logic [5:0]  opB;

  int tests = 0;
  int fails = 0;
  vec_t vecs[24];
  logic [31:0] sb[$];

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dutA (
    .clk_i(clk), .rst_i(rstA), .imem_req_o(reqA), .imem_addr_o(addrA),
    .imem_ack_i(ackA), .imem_data_i(dataA), .stall_i(stallA), .flush_i(flushA),
    .redirect_pc_i(redirA), .inst_o(instA), .pc_o(pcA), .op_o(opA), .valid_o(validA)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dutB (
    .clk_i(clk), .rst_i(rstB), .imem_req_o(reqB), .imem_addr_o(addrB),
    .imem_ack_i(ackB), .imem_data_i(dataB), .stall_i(stallB), .flush_i(flushB),
    .redirect_pc_i(redirB), .inst_o(instB), .pc_o(pcB), .op_o(opB), .valid_o(validB)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[7:2], a[25:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] w;
    //          ack stl fl drp redir         req addr          vld pc            new
    vecs[0]  = '{0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0000, 0};
    vecs[1]  = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_0004, 1};
    vecs[2]  = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0008, 1};
    vecs[3]  = '{1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0008, 0};
    vecs[4]  = '{0, 1, 0, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 0};
    vecs[5]  = '{1, 1, 0, 1, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0008, 0};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_000C, 1};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0000_000C, 0};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0000_000C, 0};
    vecs[9]  = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0010, 1};
    vecs[10] = '{0, 0, 0, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0000_0010, 0};
    vecs[11] = '{0, 0, 1, 0, 32'h0000_0040, 1, 32'h0000_0010, 0, 32'h0000_0010, 0};
    vecs[12] = '{0, 0, 0, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0000_0010, 0};
    vecs[13] = '{1, 0, 0, 1, 32'h0,         1, 32'h0000_0010, 0, 32'h0000_0010, 0};
    vecs[14] = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_0040, 1, 32'h0000_0044, 1};
    vecs[15] = '{1, 1, 0, 1, 32'h0,         1, 32'h0000_0044, 1, 32'h0000_0044, 0};
    vecs[16] = '{0, 1, 1, 0, 32'h0000_0103, 0, 32'h0000_0048, 0, 32'h0000_0044, 0};
    vecs[17] = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0104, 1};
    vecs[18] = '{1, 0, 1, 1, 32'h0000_0200, 1, 32'h0000_0104, 0, 32'h0000_0104, 0};
    vecs[19] = '{0, 1, 0, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0000_0104, 0};
    vecs[20] = '{0, 0, 1, 0, 32'h0000_0300, 1, 32'h0000_0200, 0, 32'h0000_0104, 0};
    vecs[21] = '{0, 0, 1, 0, 32'h0000_0400, 1, 32'h0000_0200, 0, 32'h0000_0104, 0};
    vecs[22] = '{1, 0, 1, 1, 32'h0000_0500, 1, 32'h0000_0200, 0, 32'h0000_0104, 0};
    vecs[23] = '{1, 0, 0, 0, 32'h0,         1, 32'h0000_0500, 1, 32'h0000_0504, 1};

    rstA = 1'b0; ackA = 1'b0; stallA = 1'b0; flushA = 1'b0; dataA = '0; redirA = '0;
    rstB = 1'b0; ackB = 1'b0; stallB = 1'b0; flushB = 1'b0; dataB = '0; redirB = '0;
    repeat (2) tick();

    check("A reset req", 32'(reqA), 32'h0);
    check("A reset addr", addrA, 32'h0);
    check("A reset inst", instA, 32'h0);
    check("A reset pc", pcA, 32'h0);
    check("A reset op", 32'(opA), 32'h0);
    check("A reset valid", 32'(validA), 32'h0);

    rstA = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("row%0d req", i), 32'(reqA), 32'(vecs[i].expReq));
      check($sformatf("row%0d addr", i), addrA, vecs[i].expAddr);
      ackA   = (vecs[i].ack != 0);
      stallA = (vecs[i].stall != 0);
      flushA = (vecs[i].flush != 0);
      redirA = vecs[i].redir;
      dataA  = ackA ? word(addrA) : 32'hDEAD_DEAD;
      if (vecs[i].ack != 0 && vecs[i].drop == 0)
        sb.push_back(word(vecs[i].expAddr));
      tick();
      check($sformatf("row%0d valid", i), 32'(validA), 32'(vecs[i].expValid));
      check($sformatf("row%0d pc", i), pcA, vecs[i].expPc);
      if (vecs[i].expNew != 0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL row%0d scoreboard: got empty queue expected an instruction", i);
        end else begin
          w = sb.pop_front();
          check($sformatf("row%0d inst", i), instA, w);
          check($sformatf("row%0d op", i), 32'(opA), 32'(w[31:26]));
        end
      end
    end
    ackA = 1'b0; stallA = 1'b0; flushA = 1'b0;
    check("A scoreboard drained", 32'(sb.size()), 32'h0);

    check("B reset addr", addrB, 32'hFFFF_FFF8);
    check("B reset req", 32'(reqB), 32'h0);
    rstB = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      check($sformatf("B wrap%0d req", k), 32'(reqB), 32'h1);
      check($sformatf("B wrap%0d addr", k), addrB, e);
      ackB  = 1'b1;
      dataB = word(addrB);
      tick();
      check($sformatf("B wrap%0d pc", k), pcB, e + 32'd4);
      check($sformatf("B wrap%0d valid", k), 32'(validB), 32'h1);
      check($sformatf("B wrap%0d inst", k), instB, word(e));
    end
    ackB = 1'b0;
    tick();
    check("B pending addr", addrB, 32'h0000_0004);
    check("B pending valid", 32'(validB), 32'h0);

    rstB = 1'b0;
    tick();
    check("B midrun reset req", 32'(reqB), 32'h0);
    check("B midrun reset addr", addrB, 32'hFFFF_FFF8);
    check("B midrun reset inst", instB, 32'h0);
    check("B midrun reset pc", pcB, 32'h0);
    check("B midrun reset op", 32'(opB), 32'h0);
    check("B midrun reset valid", 32'(validB), 32'h0);

    ackB  = 1'b1;
    dataB = word(32'h0000_0004);
    tick();
    check("B late ack valid", 32'(validB), 32'h0);
    check("B late ack inst", instB, 32'h0);
    rstB = 1'b1;
    tick();
    check("B idle ack valid", 32'(validB), 32'h0);
    check("B restart req", 32'(reqB), 32'h1);
    check("B restart addr", addrB, 32'hFFFF_FFF8);
    ackB = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the five-stage MIPS pipeline; it produces the instruction word whose opcode field drives the main control decoder. It owns the PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. It loads the IF/ID pipeline register and honours stall requests from hazard detection and flush/redirect requests from branch/jump resolution.

## Interface

- `RESET_PC`, 32'h0000_0000, fetch address after reset (word aligned)
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  reset, synchronous, active-low
- `imem_req_o`  out  1  fetch request; held high until acked
- `imem_addr_o`  out  32  fetch byte address; bits [1:0] always 0; stable while `imem_req_o`=1
- `imem_ack_i`  in  1  one-cycle acknowledge; `imem_data_i` valid the same cycle
- `imem_data_i`  in  32  instruction word
- `stall_i`  in  1  hold IF/ID contents; no new instruction accepted
- `flush_i`  in  1  squash IF/ID and everything in flight; redirect fetch
- `redirect_pc_i`  in  32  new fetch address when `flush_i`=1; bits [1:0] ignored
- `inst_o`  out  32  IF/ID instruction
- `pc_o`  out  32  IF/ID PC+4 of `inst_o`
- `op_o`  out  6  `inst_o[31:26]`, wired to the control decoder opcode input
- `valid_o`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation

- Registers: `pc_q` (next fetch address), `tgt_q` (pending redirect), buffer `buf_inst`/`buf_pc`, IF/ID (`inst_o`, `pc_o`, `valid_o`).
- States: IDLE, REQ, HOLD, SQUASH. `imem_req_o` = (state==REQ or SQUASH). `imem_addr_o` = `pc_q`.
- IDLE: entered only from reset; next edge -> REQ.
- REQ, ack, no stall: IF/ID <= {data, `pc_q`+4, valid 1}; `pc_q` <= `pc_q`+4; stay REQ (back-to-back requests, addr changes the same edge).
- REQ, ack, stall: buffer <= {data, `pc_q`+4}; `pc_q` <= `pc_q`+4; -> HOLD; IF/ID unchanged.
- REQ, no ack: if `stall_i`=0, `valid_o` <= 0 (bubble); if `stall_i`=1, IF/ID holds.
- HOLD: no request. When `stall_i`=0: IF/ID <= {buffer, valid 1}; -> REQ. While stalled, all registers hold.
- Flush has priority over stall and ack in every state; it always sets `valid_o` <= 0 and discards any buffered or acked instruction.
  - Flush in REQ with ack same cycle, in HOLD, or in IDLE: `pc_q` <= {`redirect_pc_i`[31:2],2'b00}; -> REQ.
  - Flush in REQ without ack: the memory transaction cannot be cancelled. `tgt_q` <= redirect; -> SQUASH; request to old `pc_q` stays asserted.
  - SQUASH: on ack, discard data; `pc_q` <= `tgt_q`; -> REQ. A further flush in SQUASH overwrites `tgt_q` (last wins). A flush coinciding with that ack uses the new `redirect_pc_i` directly.
  - SQUASH without ack: `valid_o` stays 0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, and `pc_o` wraps likewise.
- `imem_ack_i` outside a request is ignored.

## Timing

- Reset (`rst_i`=0 at an edge): state IDLE, `pc_q`=`RESET_PC`, `tgt_q`=0, buffer=0, `inst_o`=0, `pc_o`=0, `op_o`=0, `valid_o`=0, `imem_req_o`=0, `imem_addr_o`=`RESET_PC`. Reset overrides everything, including mid-transaction; a late ack after reset is ignored.
- After reset release: `imem_req_o` rises one cycle after the first edge with `rst_i`=1.
- Latency: ack at edge N -> `inst_o`/`valid_o` updated after edge N. With zero-wait memory (ack in the first request cycle), throughput is 1 instruction/cycle.
- Flush at edge N -> `valid_o`=0 after N. The first redirected request is issued in cycle N+1, or in the cycle after the squashed ack.
- Stall release from HOLD: buffered instruction appears after the next edge; the new request starts that same cycle.

## Test plan

- Reset, zero-wait memory returning addr-derived words -> requests at 0x0, 0x4, 0x8 on consecutive cycles; `valid_o`=1 every cycle; `pc_o`=0x4, 0x8, 0xC.
- Memory with 2 wait states -> `valid_o` pattern 0,0,1 repeating; `imem_addr_o` stable until each ack.
- Stall raised on the cycle of the ack for 0x8, held 3 cycles -> IF/ID keeps the 0x4 instruction; the 0x8 word is buffered with no request issued; after release, 0x8 appears with `pc_o`=0xC and the request for 0xC starts.
- Flush to 0x40 while the request for 0x10 is outstanding (ack 2 cycles later) -> `valid_o`=0; 0x10 data discarded; next request at 0x40.
- Flush and stall together in HOLD, `redirect_pc_i`=0x103 -> buffer dropped; next request at 0x100; `valid_o`=0.
- `RESET_PC`=0xFFFF_FFF8, zero-wait -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; `pc_o` sequence 0xFFFF_FFFC, 0x0, 0x4; `rst_i` pulsed low mid-run -> all outputs return to reset values.
